// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32 datapath.
// The master side is the sequencer; the slave side is the datapath/memory.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       InstrDone;
  logic       Illegal;
  logic [3:0] State_dbg;

  modport master (
    input  opcode, Zero, MemReady,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal, State_dbg
  );

  modport slave (
    output opcode, Zero, MemReady,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal, State_dbg
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32 integer datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// stretching the memory states with the MemReady handshake. Outputs are
// decoded from state, with IRWrite/PCWrite/InstrDone carrying the Mealy
// terms on MemReady and Zero. Write enables are gated off while Rst is high
// so an abandoned instruction cannot produce a partial write.
module multicycle_ctrl (
  input  logic               Clk,
  input  logic               Rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       illegal_r;

  logic       pc_write_s;
  logic       adr_src_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       instr_done_s;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky illegal flag, set when DECODE dispatches to TRAP.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      illegal_r <= 1'b0;
    end else if ((state_r == DECODE) && (state_nxt_s == TRAP)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_nxt_s  = state_r;
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    instr_done_s = 1'b0;
    case (state_r)
      FETCH: begin
        adr_src_s    = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b10;
        alu_op_s     = 2'b00;
        result_src_s = 2'b10;
        ir_write_s   = bus.MemReady;
        pc_write_s   = bus.MemReady;
        if (bus.MemReady) begin
          state_nxt_s = DECODE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DECODE: begin
        // PC-relative target computed here lands in ALUOut for BEQ.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b00;
        case (bus.opcode)
          OP_LW:   state_nxt_s = MEMADR;
          OP_SW:   state_nxt_s = MEMADR;
          OP_RTYP: state_nxt_s = EXECR;
          OP_IALU: state_nxt_s = EXECI;
          OP_BEQ:  state_nxt_s = BEQ;
          OP_JAL:  state_nxt_s = JAL;
          default: state_nxt_s = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b00;
        if (bus.opcode == OP_SW) begin
          state_nxt_s = MEMWRITE;
        end else begin
          state_nxt_s = MEMREAD;
        end
      end
      MEMREAD: begin
        adr_src_s    = 1'b1;
        result_src_s = 2'b00;
        if (bus.MemReady) begin
          state_nxt_s = MEMWB;
        end else begin
          state_nxt_s = MEMREAD;
        end
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_nxt_s  = FETCH;
      end
      MEMWRITE: begin
        // Write is held every cycle; memory tolerates the repeat.
        adr_src_s    = 1'b1;
        result_src_s = 2'b00;
        mem_write_s  = 1'b1;
        instr_done_s = bus.MemReady;
        if (bus.MemReady) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = MEMWRITE;
        end
      end
      EXECR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b00;
        alu_op_s    = 2'b10;
        state_nxt_s = ALUWB;
      end
      EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        state_nxt_s = ALUWB;
      end
      ALUWB: begin
        result_src_s = 2'b00;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_nxt_s  = FETCH;
      end
      BEQ: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b01;
        result_src_s = 2'b00;
        pc_write_s   = bus.Zero;
        instr_done_s = 1'b1;
        state_nxt_s  = FETCH;
      end
      JAL: begin
        alu_src_a_s  = 2'b01;
        alu_src_b_s  = 2'b10;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        pc_write_s   = 1'b1;
        state_nxt_s  = ALUWB;
      end
      TRAP: begin
        state_nxt_s = TRAP;
      end
      default: begin
        // Unused encodings recover to FETCH.
        state_nxt_s = FETCH;
      end
    endcase
  end

  // Enables are forced off while Rst is high, independent of MemReady.
  assign bus.PCWrite   = pc_write_s   & ~Rst;
  assign bus.IRWrite   = ir_write_s   & ~Rst;
  assign bus.MemWrite  = mem_write_s  & ~Rst;
  assign bus.RegWrite  = reg_write_s  & ~Rst;
  assign bus.InstrDone = instr_done_s & ~Rst;
  assign bus.AdrSrc    = adr_src_s;
  assign bus.ResultSrc = result_src_s;
  assign bus.ALUSrcA   = alu_src_a_s;
  assign bus.ALUSrcB   = alu_src_b_s;
  assign bus.ALUOp     = alu_op_s;
  assign bus.Illegal   = illegal_r;
  assign bus.State_dbg = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes the
// expected state and control word for each cycle it drives; a monitor pops
// and compares on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b0000000;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctl;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  always #5 Clk = ~Clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Expected control word straight from the per-state output table.
  // Packing: {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,InstrDone,Illegal}
  function automatic logic [14:0] ctl_of(input logic [3:0] st, input logic mr,
                                         input logic z, input logic r);
    logic pcw, adr, irw, mw, rw, done, ill;
    logic [1:0] rs, sa, sb, op;
    pcw = 1'b0; adr = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0;
    done = 1'b0; ill = 1'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; op = 2'b00;
    case (st)
      4'd0:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  begin adr = 1'b1; end
      4'd4:  begin rs = 2'b01; rw = 1'b1; done = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; done = mr; end
      4'd6:  begin sa = 2'b10; sb = 2'b00; op = 2'b10; end
      4'd7:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
      4'd8:  begin rw = 1'b1; done = 1'b1; end
      4'd9:  begin sa = 2'b10; op = 2'b01; pcw = z; done = 1'b1; end
      4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      4'd11: begin ill = 1'b1; end
      default: begin end
    endcase
    if (r) begin
      pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; done = 1'b0;
    end
    return {pcw, adr, irw, mw, rw, rs, sa, sb, op, done, ill};
  endfunction

  // One cycle: drive inputs just after the edge, queue what that cycle must show.
  task automatic step(input logic r, input logic [6:0] opc, input logic mr,
                      input logic z, input logic [3:0] st);
    @(posedge Clk);
    #1;
    Rst          = r;
    bus.opcode   = opc;
    bus.MemReady = mr;
    bus.Zero     = z;
    q.push_back({st, ctl_of(st, mr, z, r)});
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge Clk) begin
    exp_t e;
    logic [14:0] act;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite, bus.RegWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
             bus.InstrDone, bus.Illegal};
      checks++;
      if (bus.State_dbg !== e.st) begin
        errors++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, bus.State_dbg, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl t=%0t state=%0d got=%b want=%b", $time, e.st, act, e.ctl);
      end
    end
  end

  initial begin
    Rst          = 1'b1;
    bus.opcode   = 7'd0;
    bus.MemReady = 1'b1;
    bus.Zero     = 1'b0;

    // Reset held with MemReady=1: enables must stay low.
    step(1'b1, OP_RTYP, 1'b1, 1'b0, 4'd0);

    // R-type: 0,1,6,8 (DECODE ignores MemReady=0)
    step(1'b0, OP_RTYP, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_RTYP, 1'b0, 1'b0, 4'd1);
    step(1'b0, OP_RTYP, 1'b1, 1'b0, 4'd6);
    step(1'b0, OP_RTYP, 1'b1, 1'b0, 4'd8);

    // lw with one FETCH stall and two MEMREAD stalls: 0,0,1,2,3,3,3,4
    step(1'b0, OP_LW, 1'b0, 1'b0, 4'd0);
    step(1'b0, OP_LW, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_LW, 1'b1, 1'b0, 4'd1);
    step(1'b0, OP_LW, 1'b1, 1'b0, 4'd2);
    step(1'b0, OP_LW, 1'b0, 1'b0, 4'd3);
    step(1'b0, OP_LW, 1'b0, 1'b0, 4'd3);
    step(1'b0, OP_LW, 1'b1, 1'b0, 4'd3);
    step(1'b0, OP_LW, 1'b0, 1'b0, 4'd4);

    // beq taken then not taken
    step(1'b0, OP_BEQ, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_BEQ, 1'b1, 1'b0, 4'd1);
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 4'd9);
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 4'd0);
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 4'd1);
    step(1'b0, OP_BEQ, 1'b1, 1'b0, 4'd9);

    // jal: 0,1,10,8
    step(1'b0, OP_JAL, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_JAL, 1'b1, 1'b0, 4'd1);
    step(1'b0, OP_JAL, 1'b1, 1'b0, 4'd10);
    step(1'b0, OP_JAL, 1'b1, 1'b0, 4'd8);

    // I-ALU: opcode scribbled in ALUWB must not matter
    step(1'b0, OP_IALU, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_IALU, 1'b1, 1'b0, 4'd1);
    step(1'b0, OP_IALU, 1'b1, 1'b0, 4'd7);
    step(1'b0, OP_BAD,  1'b1, 1'b0, 4'd8);

    // sw completing immediately
    step(1'b0, OP_SW, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_SW, 1'b1, 1'b0, 4'd1);
    step(1'b0, OP_SW, 1'b1, 1'b0, 4'd2);
    step(1'b0, OP_SW, 1'b1, 1'b0, 4'd5);

    // Illegal opcode: TRAP held for 10 cycles, then reset clears it
    step(1'b0, OP_BAD, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_BAD, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, OP_LW, i[0], ~i[0], 4'd11);
    end
    step(1'b1, OP_BAD, 1'b1, 1'b0, 4'd0);

    // sw stalled in MEMWRITE, then reset mid-cycle aborts it
    step(1'b0, OP_SW, 1'b1, 1'b0, 4'd0);
    step(1'b0, OP_SW, 1'b1, 1'b0, 4'd1);
    step(1'b0, OP_SW, 1'b1, 1'b0, 4'd2);
    step(1'b0, OP_SW, 1'b0, 1'b0, 4'd5);
    step(1'b0, OP_SW, 1'b0, 1'b0, 4'd5);
    step(1'b1, OP_SW, 1'b0, 1'b0, 4'd0);
    step(1'b0, OP_SW, 1'b0, 1'b0, 4'd0);
    step(1'b0, OP_SW, 1'b0, 1'b0, 4'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && q.size() != 0; i++) begin
      @(posedge Clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32 integer datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. The instruction memory, data memory and register file are thereby used over several shorter cycles instead of one long cycle. It drives the datapath mux selects and write enables, and its `ALUOp` output feeds the existing `AluCtrl` decoder. It also stretches memory states with a ready handshake.

## Interface
- No parameters; encodings are fixed below.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `opcode`  in  7  `Instr[6:0]` from the instruction register; stable from DECODE until the return to FETCH.
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  PC register load enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `IRWrite`  out  1  instruction register and OldPC load enable.
- `MemWrite`  out  1  memory write enable.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result select: 00 = ALUOut register, 01 = memory data register, 10 = ALU result (combinational).
- `ALUSrcA`  out  2  ALU input A: 00 = PC, 01 = OldPC, 10 = register A.
- `ALUSrcB`  out  2  ALU input B: 00 = register B, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = funct-decoded; same coding as `AluCtrl`.
- `InstrDone`  out  1  one-cycle pulse in the final cycle of each instruction.
- `Illegal`  out  1  sticky flag: unsupported opcode decoded.
- `State_dbg`  out  4  current state encoding.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Per-state outputs. Any output not listed is 0; unlisted selects are 0 (don't-care).
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=MemReady.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. The branch target is latched into ALUOut.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held every cycle in this state; memory must tolerate the repeated write.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - TRAP: Illegal=1.
- Transitions:
  - FETCH → DECODE if MemReady; otherwise stays in FETCH.
  - DECODE → MEMADR for lw or sw, EXECR, EXECI, BEQ or JAL per opcode. Any other opcode → TRAP.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB if MemReady; otherwise stays in MEMREAD.
  - MEMWRITE → FETCH if MemReady; otherwise stays in MEMWRITE.
  - MEMWB, ALUWB and BEQ → FETCH.
  - EXECR, EXECI and JAL → ALUWB.
  - TRAP → TRAP until Rst.
- InstrDone=1 in MEMWB, ALUWB, BEQ, and in MEMWRITE when MemReady=1.
- Outputs are Moore decoded from state, except the Mealy terms IRWrite/PCWrite (MemReady in FETCH, Zero in BEQ) and InstrDone (MemReady in MEMWRITE).

## Timing
- Asynchronous reset: state=FETCH and Illegal=0 immediately.
- While Rst=1, PCWrite, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0, regardless of MemReady.
- After Rst release, outputs are FETCH values; State_dbg=0.
- Latency with MemReady tied to 1:
  - lw: 5 cycles.
  - sw, R-type, I-ALU, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. The other states ignore MemReady.
- Reset mid-instruction abandons it; no partial write occurs after Rst rises.
- `opcode` is sampled only in DECODE and MEMADR. Changes in other states have no effect.

## Test plan
- Reset, MemReady=1, opcode=0110011:
  - State_dbg sequence is 0,1,6,8,0.
  - RegWrite=1 only in state 8; ALUOp=10 in state 6.
  - InstrDone pulses once in cycle 4.
- lw (0000011), MemReady=0 for 2 cycles in MEMREAD and 1 cycle in FETCH:
  - Sequence is 0,0,1,2,3,3,3,4,0.
  - IRWrite=1 only in the second FETCH cycle; RegWrite=1 only in state 4 with ResultSrc=01.
- beq (1100011):
  - Zero=1 in BEQ gives PCWrite=1.
  - Zero=0 gives PCWrite=0.
  - Both cases take 3 cycles and end with InstrDone=1.
- jal (1101111):
  - Sequence is 0,1,10,8,0.
  - PCWrite=1 in FETCH and JAL; RegWrite=1 in ALUWB with ResultSrc=00.
- Illegal opcode 0000000:
  - State goes to 11 and Illegal=1; it holds for 10 cycles with all enables 0.
  - Rst clears to state 0 with Illegal=0.
- sw (0100011) with MemReady=0 and Rst asserted in MEMWRITE:
  - MemWrite falls to 0 in the same cycle, before the clock edge.
  - State_dbg=0 and there is no InstrDone pulse.
